wm8750_config: RTL

WM8750_CONFIG -- requirements
Module: wm8750_config

---
 rtl/wm8750_pkg.sv | 47 ++++
 rtl/wm8750_init_rom.sv | 28 ++
 rtl/wm8750_config.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/wm8750_pkg.sv
// Shared definitions for the WM8750 codec configuration block: register
// addresses, the 16-bit init-table entry and the walker FSM states.
package wm8750_pkg;

    // 7-bit codec address with CSB tied low.
    localparam logic [6:0] WM_DEV_ADDR = 7'h1A;

    typedef enum logic [6:0] {
        R0_LINVOL      = 7'h00,
        R1_RINVOL      = 7'h01,
        R2_LOUT1VOL    = 7'h02,
        R3_ROUT1VOL    = 7'h03,
        R5_ADCDAC_CTRL = 7'h05,
        R7_AUDIO_INTFC = 7'h07,
        R8_SAMPLE_RATE = 7'h08,
        R10_LDAC_VOL   = 7'h0A,
        R11_RDAC_VOL   = 7'h0B,
        R15_RESET      = 7'h0F,
        R25_PWR_MGMT1  = 7'h19,
        R26_PWR_MGMT2  = 7'h1A,
        R34_LEFT_MIX1  = 7'h22,
        R37_RIGHT_MIX2 = 7'h25
    } wm_reg_e;

    typedef struct packed {
        logic [6:0] addr;
        logic [8:0] data;
    } wm_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BITS,
        ST_ACK,
        ST_STOP,
        ST_GAP,
        ST_FINISH
    } cfg_state_e;

    function automatic wm_entry_t mk_entry(input wm_reg_e addr, input logic [8:0] data);
        wm_entry_t e;
        e.addr = addr;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/wm8750_init_rom.sv
// Codec init table: reset, interface format matching the DSP-B serializer,
// USB clocking, then power, volume and output mixer routing.
module wm8750_init_rom
    import wm8750_pkg::*;
(
    input  logic [3:0] idx_i,
    output wm_entry_t  entry_o
);

    always_comb begin
        entry_o = mk_entry(R15_RESET, 9'h000);
        case (idx_i)
            4'd0:    entry_o = mk_entry(R15_RESET,      9'h000);
            4'd1:    entry_o = mk_entry(R7_AUDIO_INTFC, 9'h013); // slave, DSP mode B, 16-bit
            4'd2:    entry_o = mk_entry(R8_SAMPLE_RATE, 9'h001); // USB mode, MCLK = BCLK
            4'd3:    entry_o = mk_entry(R25_PWR_MGMT1,  9'h0C0);
            4'd4:    entry_o = mk_entry(R26_PWR_MGMT2,  9'h1E0);
            4'd5:    entry_o = mk_entry(R34_LEFT_MIX1,  9'h150);
            4'd6:    entry_o = mk_entry(R37_RIGHT_MIX2, 9'h150);
            4'd7:    entry_o = mk_entry(R2_LOUT1VOL,    9'h179);
            4'd8:    entry_o = mk_entry(R3_ROUT1VOL,    9'h179);
            4'd9:    entry_o = mk_entry(R10_LDAC_VOL,   9'h1FF);
            4'd10:   entry_o = mk_entry(R5_ADCDAC_CTRL, 9'h000); // clear DAC soft mute
            default: entry_o = mk_entry(R15_RESET,      9'h000);
        endcase
    end

endmodule

// File: rtl/wm8750_config.sv
// I2C master that walks the WM8750 init table once per start pulse, one
// write transaction per entry, aborting the walk on any NACK.
module wm8750_config
    import wm8750_pkg::*;
#(
    parameter int         CLK_DIV  = 63,
    parameter logic [6:0] DEV_ADDR = WM_DEV_ADDR,
    parameter int         NUM_REGS = 11
) (
    input  logic clk25,
    input  logic reset25,
    input  logic start,
    output logic busy,
    output logic done,
    output logic error,
    output logic scl_oe,
    output logic sda_oe,
    input  logic sda_in
);

    // Control handshake: start is honoured only in IDLE; busy rises the next
    // cycle and falls in the single cycle that done pulses.
    localparam logic [9:0] DIV_LAST = 10'(CLK_DIV - 1);
    localparam logic [3:0] IDX_LAST = 4'(NUM_REGS - 1);

    cfg_state_e state_q, state_d;
    logic [9:0] div_q, div_d;
    logic [1:0] qtr_q, qtr_d;
    logic [2:0] bit_q, bit_d;
    logic [1:0] byte_q, byte_d;
    logic [3:0] idx_q, idx_d;
    logic       nack_q, nack_d;
    logic       abort_q, abort_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       error_q, error_d;
    logic       scl_q, scl_d;
    logic       sda_q, sda_d;
    logic       tick, unit_end;
    wm_entry_t  entry;
    logic [7:0] tx_byte;
    logic       tx_bit;

    wm8750_init_rom u_rom (
        .idx_i   (idx_d),
        .entry_o (entry)
    );

    assign tick     = busy_q && (div_q == DIV_LAST);
    assign unit_end = tick && (qtr_q == 2'd3);

    always_comb begin
        state_d = state_q;
        div_d   = 10'd0;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        idx_d   = idx_q;
        nack_d  = nack_q;
        abort_d = abort_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        error_d = error_q;
        if (busy_q) div_d = tick ? 10'd0 : div_q + 10'd1;
        if (tick) qtr_d = qtr_q + 2'd1;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_START;
                    busy_d  = 1'b1;
                    error_d = 1'b0;
                    idx_d   = 4'd0;
                    abort_d = 1'b0;
                    nack_d  = 1'b0;
                    qtr_d   = 2'd0;
                end
            end
            ST_START: begin
                if (unit_end) begin
                    state_d = ST_BITS;
                    bit_d   = 3'd0;
                    byte_d  = 2'd0;
                end
            end
            ST_BITS: begin
                if (unit_end) begin
                    if (bit_q == 3'd7) state_d = ST_ACK;
                    else bit_d = bit_q + 3'd1;
                end
            end
            ST_ACK: begin
                // Slave acknowledge is judged on the last cycle of q2.
                if (tick && (qtr_q == 2'd2) && sda_in) begin
                    nack_d  = 1'b1;
                    error_d = 1'b1;
                end
                if (unit_end) begin
                    nack_d = 1'b0;
                    if (nack_q) begin
                        abort_d = 1'b1;
                        state_d = ST_STOP;
                    end else if (byte_q == 2'd2) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_BITS;
                        bit_d   = 3'd0;
                        byte_d  = byte_q + 2'd1;
                    end
                end
            end
            ST_STOP: begin
                if (unit_end) state_d = ST_GAP;
            end
            ST_GAP: begin
                if (unit_end) begin
                    if (abort_q || (idx_q == IDX_LAST)) begin
                        state_d = ST_FINISH;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_START;
                        idx_d   = idx_q + 4'd1;
                    end
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Line drive is derived from the next state so the registered pins line
    // up exactly with unit and quarter boundaries.
    always_comb begin
        case (byte_d)
            2'd0:    tx_byte = {DEV_ADDR, 1'b0};
            2'd1:    tx_byte = entry[15:8];
            default: tx_byte = entry[7:0];
        endcase
        tx_bit = tx_byte[3'd7 - bit_d];
        scl_d  = 1'b0;
        sda_d  = 1'b0;
        case (state_d)
            ST_START: begin
                scl_d = 1'b0;
                sda_d = qtr_d[1];
            end
            ST_BITS: begin
                scl_d = ~qtr_d[1];
                sda_d = ~tx_bit;
            end
            ST_ACK: begin
                scl_d = ~qtr_d[1];
                sda_d = 1'b0;
            end
            ST_STOP: begin
                scl_d = (qtr_d == 2'd0);
                sda_d = ~qtr_d[1];
            end
            default: begin
                scl_d = 1'b0;
                sda_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk25) begin
        if (reset25) begin
            state_q <= ST_IDLE;
            div_q   <= 10'd0;
            qtr_q   <= 2'd0;
            bit_q   <= 3'd0;
            byte_q  <= 2'd0;
            idx_q   <= 4'd0;
            nack_q  <= 1'b0;
            abort_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            scl_q   <= 1'b0;
            sda_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            idx_q   <= idx_d;
            nack_q  <= nack_d;
            abort_q <= abort_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign error  = error_q;
    assign scl_oe = scl_q;
    assign sda_oe = sda_q;

endmodule
